core_apb_arbiter: RTL

- Shares the single APB master port between two requesters using valid/ready request interfaces: r0 (core memory interface) and r1 (debug/DMA port).
- Sequences each APB transfer through SETUP and ACCESS phases.
- Arbitrates between the requesters by round-robin or fixed priority.
- Aborts transfers whose completer never responds, returning an error.

---
 rtl/core_apb_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/core_apb_arbiter.sv
// core_apb_arbiter: shares one APB master port between two valid/ready
// requesters. Each transfer goes through SETUP and ACCESS. Requesters are
// picked round-robin or by fixed priority. A stalled completer is aborted
// after TIMEOUT_CYCLES, and the requester gets an error response.
module core_apb_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_addr,
  input  logic        r0_write,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_wstrb,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_addr,
  input  logic        r1_write,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_wstrb,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        psel,
  output logic        penable,
  input  logic        pready,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic [31:0] prdata,
  input  logic        pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;        // 0 = r0, 1 = r1
  logic          last_q, last_d;          // most recent grant
  logic [CW-1:0] cnt_q, cnt_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic [31:0]   paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pwstrb_q, pwstrb_d;

  logic          done_s;
  logic          err_s;
  logic [31:0]   rdata_s;
  logic          arb_v0_s, arb_v1_s;
  logic          win_s;
  logic          timeout_s;
  logic          done0_s, done1_s;

  // Winner among the (possibly masked) valids; ties go to the fixed winner r0
  // or to whichever requester was not granted last.
  function automatic logic pick(input logic v0, input logic v1, input logic last);
    logic w;
    if (v0 && v1) begin
      w = (PRIORITY_MODE == 1) ? 1'b0 : ~last;
    end else if (v1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  assign timeout_s = (TIMEOUT_CYCLES > 0) ? (cnt_q == CNT_LAST) : 1'b0;

  // Next-state, APB field capture and completion/abort decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pwstrb_d  = pwstrb_q;
    done_s    = 1'b0;
    err_s     = 1'b0;
    rdata_s   = 32'h0000_0000;
    arb_v0_s  = 1'b0;
    arb_v1_s  = 1'b0;
    win_s     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = {CW{1'b0}};
        arb_v0_s = r0_valid;
        arb_v1_s = r1_valid;
      end
      SETUP: begin
        cnt_d   = {CW{1'b0}};
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done_s  = 1'b1;
          err_s   = pslverr;
          rdata_s = pwrite_q ? 32'h0000_0000 : prdata;
        end else if (timeout_s) begin
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          cnt_d = (TIMEOUT_CYCLES > 0) ? (cnt_q + CW'(1)) : {CW{1'b0}};
        end
        if (done_s) begin
          // The finishing requester's valid still describes the request
          // being retired, so it is masked out of the re-arbitration.
          cnt_d    = {CW{1'b0}};
          arb_v0_s = r0_valid & grant_q;
          arb_v1_s = r1_valid & ~grant_q;
          state_d  = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_v0_s || arb_v1_s) begin
      win_s    = pick(arb_v0_s, arb_v1_s, last_q);
      grant_d  = win_s;
      last_d   = win_s;
      paddr_d  = win_s ? r1_addr  : r0_addr;
      pwrite_d = win_s ? r1_write : r0_write;
      pwdata_d = win_s ? r1_wdata : r0_wdata;
      if (win_s ? r1_write : r0_write) begin
        pwstrb_d = win_s ? r1_wstrb : r0_wstrb;
      end else begin
        pwstrb_d = 4'b0000;
      end
      state_d  = SETUP;
    end else begin
      win_s = 1'b0;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State, arbitration history, timeout counter and registered APB outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= {CW{1'b0}};
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= 32'h0000_0000;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0000_0000;
      pwstrb_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pwstrb_q  <= pwstrb_d;
    end
  end

  // A transfer cut short by reset never reports completion.
  assign done0_s  = done_s & ~grant_q & ~rst;
  assign done1_s  = done_s &  grant_q & ~rst;

  assign r0_ready = done0_s;
  assign r0_err   = done0_s & err_s;
  assign r0_rdata = done0_s ? rdata_s : 32'h0000_0000;
  assign r1_ready = done1_s;
  assign r1_err   = done1_s & err_s;
  assign r1_rdata = done1_s ? rdata_s : 32'h0000_0000;

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign paddr    = paddr_q;
  assign pwrite   = pwrite_q;
  assign pwdata   = pwdata_q;
  assign pwstrb   = pwstrb_q;

endmodule
